decoder_scan_n: RTL and testbench
=================================

# decoder_scan_n

Parametrised, registered N-to-NUM_OUT one-hot decoder with two modes. Direct mode decodes a selector accepted through a valid/ready handshake. Scan mode runs an internal counter that walks the outputs with a programmable dwell time. It is the successor to the fixed 3-to-8 combinational decoder, and drives multiplexed digit and row enables, bank selects and chip selects.

## Interface
- SEL_W, default 3: selector and index width.
- NUM_OUT, default 8: number of outputs; legal range 2 to 2**SEL_W.
- DWELL_W, default 8: width of the dwell count.
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: block enable.
- mode, input, 1: 0 = direct, 1 = scan.
- sel_valid, input, 1: a selector is offered on sel.
- sel, input, SEL_W: selector value in direct mode.
- sel_ready, output, 1: the block accepts sel this cycle. Combinational: en & ~mode & ~rst.
- dwell, input, DWELL_W: scan hold count; each position is held for dwell+1 cycles.
- y, output, NUM_OUT: registered one-hot (or all-zero) decoded output.
- idx, output, SEL_W: registered index of the currently asserted output.
- err, output, 1: sticky flag for an out-of-range selector.
- wrap, output, 1: one-cycle pulse when a scan completes a full sweep.

## Operation
- Reset, or en=0 at an edge: y=0, idx=0, err=0, wrap=0, dwell counter=0, state=IDLE.
- States:
  - IDLE: en=0.
  - DIRECT: en=1, mode=0.
  - SCAN: en=1, mode=1.
  - BLANK: exists only with the macro defined.
- The state is re-evaluated every cycle from en and mode. The mode input has priority over an in-progress dwell.
- DIRECT behaviour:
  - A transfer happens when sel_valid & sel_ready.
  - If sel < NUM_OUT: y = 1<<sel, idx = sel, err = 0.
  - Else: y = 0, idx is unchanged, err = 1.
  - Without a transfer, y, idx and err hold.
  - err stays set until the next in-range transfer, a reset, or en=0.
- Entering DIRECT from SCAN: y=0 and err=0 on the first DIRECT edge. If a valid transfer happens on that same edge, the transfer wins.
- SCAN behaviour:
  - Entering SCAN from any state: idx=0, y=1<<0, dwell counter loaded with dwell.
  - Each subsequent edge with counter≠0 decrements the counter.
  - When counter=0, idx advances to idx+1, wrapping from NUM_OUT-1 to 0 (never to 2**SEL_W-1). y follows the new idx and the counter reloads from the current dwell.
- dwell is sampled only at load. A change mid-position takes effect at the next position.
- wrap is asserted on the edge where idx goes from NUM_OUT-1 to 0.
- In SCAN, sel_ready=0 and sel is ignored. err is cleared on SCAN entry.
- dwell=0 means the scan advances every cycle.

## Timing
- Direct latency: a transfer at edge k gives y valid after edge k, i.e. 1 cycle. Throughput is one selector per cycle.
- Scan entry: mode rises before edge k, so y=0x01 after edge k.
- Each position is asserted for exactly dwell+1 cycles.
- Sweep period is NUM_OUT*(dwell+1) cycles, or NUM_OUT*(dwell+2) with blanking.
- wrap coincides with the first cycle in which y[0] is asserted for the new sweep.
- y is always one-hot or zero. It is never multi-hot, including across mode changes.
- A reset asserted mid-dwell takes effect at the next edge. The scan restarts at idx 0 only after rst is released and SCAN is re-entered.

## Configuration
- DECODER_SCAN_BLANK_EN:
  - Defined: at each scan advance, a one-cycle BLANK state is inserted. In BLANK, y=0, idx holds the old value, and the counter is not loaded.
  - On the following edge, idx and y take the next position and the counter loads. wrap pulses on that edge.
  - The gap gives break-before-make for display ghosting and bus-contention avoidance.
  - Not defined: there is no BLANK state and positions are back-to-back.
  - DIRECT mode is unaffected either way.

## Test plan
- Reset/enable: rst=1 for 2 cycles, then en=0 → y=0, idx=0, err=0, wrap=0, sel_ready=0. Then en=1, mode=0 → sel_ready=1.
- Direct decode, default parameters: sel=0..7 with sel_valid=1 back-to-back → y=0x01,0x02,…,0x80 one cycle after each, idx equal to sel.
- Out of range (NUM_OUT=6, SEL_W=3): sel=6 → y=0, err=1, and err holds with sel_valid=0. Then sel=2 → y=0x04, err=0.
- Scan, dwell=2, NUM_OUT=8 → each bit high for 3 cycles in order 0x01…0x80, period 24 cycles, wrap pulses once per sweep. Changing dwell to 0 mid-position takes effect from the next position.
- Mode switch: in scan at idx=5, set mode=0 with sel_valid=1, sel=3 → next y=0x08, never multi-hot. Then mode=1 → y=0x01, idx=0.
- With DECODER_SCAN_BLANK_EN, dwell=1 → each position gives 2 cycles high then 1 cycle y=0, period 24 for NUM_OUT=8. A mid-scan rst gives y=0 on the next edge.

Source files
------------

// File: rtl/decoder_scan_n.sv
// -----------------------------------------------------------------------------
// decoder_scan_n
//
// Registered SEL_W-to-NUM_OUT one-hot decoder with two modes:
//   direct (mode=0): decodes a selector taken through a valid/ready handshake.
//   scan   (mode=1): an internal counter walks the outputs, holding each
//                    position for dwell+1 cycles.
// Drives multiplexed digit/row enables, bank selects and chip selects.
//
// Optional build macro:
//   DECODER_SCAN_BLANK_EN - inserts a one-cycle all-zero BLANK state at each
//                           scan advance (break-before-make). Direct mode is
//                           unaffected.
//
// Handshake: a selector transfers on a rising edge where sel_valid & sel_ready
// are both high. sel_ready is combinational (en & ~mode & ~rst) and does not
// depend on sel_valid; sel_valid may be raised or dropped at any time.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   en         in   block enable; en=0 clears outputs and returns to IDLE
//   mode       in   0 = direct, 1 = scan
//   sel_valid  in   selector offered on sel
//   sel        in   [SEL_W]   selector value (direct mode)
//   sel_ready  out  selector accepted this cycle
//   dwell      in   [DWELL_W] scan hold count (sampled only at position load)
//   y          out  [NUM_OUT] registered one-hot or all-zero output
//   idx        out  [SEL_W]   registered index of the asserted output
//   err        out  sticky out-of-range selector flag
//   wrap       out  one-cycle pulse when a scan sweep completes
//   dbg_state  out  [2] current FSM state (0 IDLE, 1 DIRECT, 2 SCAN, 3 BLANK)
// -----------------------------------------------------------------------------
module decoder_scan_n #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   idx,
  output logic               err,
  output logic               wrap,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
`ifdef DECODER_SCAN_BLANK_EN
    ,
    BLANK  = 2'd3
`endif
  } state_t;

  // One extra bit so NUM_OUT = 2**SEL_W is representable in the range test.
  localparam logic [SEL_W:0]   NUM_OUT_V = (SEL_W + 1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);

  state_t             state, state_n;
  logic [NUM_OUT-1:0] y_n;
  logic [SEL_W-1:0]   idx_n;
  logic               err_n;
  logic               wrap_n;
  logic [DWELL_W-1:0] cnt, cnt_n;

  logic               sel_in_range;
  logic [SEL_W-1:0]   idx_adv;
  logic               in_scan;

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [NUM_OUT-1:0] o;
    o = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      o[k] = (i == SEL_W'(k));
    end
    return o;
  endfunction

  assign sel_ready = en & ~mode & ~rst;
  assign dbg_state = state;

  assign sel_in_range = ({1'b0, sel} < NUM_OUT_V);
  // Wrap at NUM_OUT-1, never at 2**SEL_W-1.
  assign idx_adv      = (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
`ifdef DECODER_SCAN_BLANK_EN
  assign in_scan      = (state == SCAN) || (state == BLANK);
`else
  assign in_scan      = (state == SCAN);
`endif

  always_comb begin
    state_n = state;
    y_n     = y;
    idx_n   = idx;
    err_n   = err;
    wrap_n  = 1'b0;
    cnt_n   = cnt;

    if (!en) begin
      state_n = IDLE;
      y_n     = '0;
      idx_n   = '0;
      err_n   = 1'b0;
      cnt_n   = '0;
    end else if (!mode) begin
      state_n = DIRECT;
      cnt_n   = '0;
      // Leaving scan: drop the scan output first so a later transfer cannot
      // leave two bits set; a transfer on this same edge overrides below.
      if (state != DIRECT) begin
        y_n   = '0;
        err_n = 1'b0;
      end
      if (sel_valid) begin
        if (sel_in_range) begin
          y_n   = onehot(sel);
          idx_n = sel;
          err_n = 1'b0;
        end else begin
          y_n   = '0;
          err_n = 1'b1;
        end
      end
    end else if (!in_scan) begin
      // Scan entry from IDLE or DIRECT always restarts at position 0.
      state_n = SCAN;
      idx_n   = '0;
      y_n     = onehot('0);
      cnt_n   = dwell;
      err_n   = 1'b0;
    end else if ((state == SCAN) && (cnt != '0)) begin
      cnt_n = cnt - DWELL_W'(1);
    end else begin
`ifdef DECODER_SCAN_BLANK_EN
      if (state == SCAN) begin
        // Dwell expired: one all-zero cycle, idx and counter hold.
        state_n = BLANK;
        y_n     = '0;
      end else begin
        state_n = SCAN;
        idx_n   = idx_adv;
        y_n     = onehot(idx_adv);
        cnt_n   = dwell;
        wrap_n  = (idx == LAST_IDX);
      end
`else
      state_n = SCAN;
      idx_n   = idx_adv;
      y_n     = onehot(idx_adv);
      cnt_n   = dwell;
      wrap_n  = (idx == LAST_IDX);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      y     <= '0;
      idx   <= '0;
      err   <= 1'b0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      y     <= y_n;
      idx   <= idx_n;
      err   <= err_n;
      wrap  <= wrap_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan_n.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_n
//
// Bench for decoder_scan_n. Two instances share all inputs: dut8 (default
// parameters) and dut6 (NUM_OUT=6) for out-of-range selectors. Direct-mode
// behaviour is driven from a vector table; scan, mode switches and reset are
// hand-written sequences. Inputs change 1 time unit after the rising edge,
// outputs are sampled at that point too.
// -----------------------------------------------------------------------------
module tb_decoder_scan_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       sel_valid;
  logic [2:0] sel;
  logic [7:0] dwell;

  logic       sel_ready8, sel_ready6;
  logic [7:0] y8;
  logic [5:0] y6;
  logic [2:0] idx8, idx6;
  logic       err8, err6;
  logic       wrap8, wrap6;
  logic [1:0] st8, st6;

  int n_assert = 0;
  int n_fail   = 0;
  logic mon_on = 1'b0;

  decoder_scan_n #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel), .sel_ready(sel_ready8), .dwell(dwell), .y(y8), .idx(idx8),
    .err(err8), .wrap(wrap8), .dbg_state(st8)
  );

  decoder_scan_n #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(8)) dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel), .sel_ready(sel_ready6), .dwell(dwell), .y(y6), .idx(idx6),
    .err(err6), .wrap(wrap6), .dbg_state(st6)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // y must never be multi-hot, including across mode changes.
  always @(negedge clk) begin
    if (mon_on) begin
      n_assert++;
      if (!($countones(y8) <= 1) || !($countones(y6) <= 1)) begin
        n_fail++;
        $display("FAIL onehot: got y8=%0h y6=%0h expected at most one bit", y8, y6);
      end
    end
  end

  // Check one scan position on dut8: hold cycles high, optional wrap on the
  // first one, then a blank cycle when blanking is built in.
  task automatic check_pos(input int p, input int hold, input bit wrap_first);
    logic [7:0] e;
    e = 8'h01 << p;
    for (int c = 0; c < hold; c++) begin
      chk("scan_y", 32'(y8), 32'(e));
      chk("scan_idx", 32'(idx8), 32'(p));
      chk("scan_wrap", 32'(wrap8), 32'((wrap_first && c == 0) ? 1 : 0));
      step();
    end
`ifdef DECODER_SCAN_BLANK_EN
    chk("blank_y", 32'(y8), 32'h0);
    chk("blank_idx", 32'(idx8), 32'(p));
    chk("blank_wrap", 32'(wrap8), 32'h0);
    step();
`endif
  endtask

  // ---------------- direct-mode vector table ----------------
  typedef struct {
    logic       en;
    logic       valid;
    logic [2:0] sel;
    logic [7:0] y8;
    logic [2:0] idx8;
    logic       err8;
    logic [5:0] y6;
    logic [2:0] idx6;
    logic       err6;
  } vec_t;

  vec_t vt[17];

  initial begin
    //          en  v   sel   y8     i8    e8    y6     i6    e6
    vt[0]  = '{1'b1,1'b1,3'd0,8'h01,3'd0,1'b0,6'h01,3'd0,1'b0};
    vt[1]  = '{1'b1,1'b1,3'd1,8'h02,3'd1,1'b0,6'h02,3'd1,1'b0};
    vt[2]  = '{1'b1,1'b1,3'd2,8'h04,3'd2,1'b0,6'h04,3'd2,1'b0};
    vt[3]  = '{1'b1,1'b1,3'd3,8'h08,3'd3,1'b0,6'h08,3'd3,1'b0};
    vt[4]  = '{1'b1,1'b1,3'd4,8'h10,3'd4,1'b0,6'h10,3'd4,1'b0};
    vt[5]  = '{1'b1,1'b1,3'd5,8'h20,3'd5,1'b0,6'h20,3'd5,1'b0};
    vt[6]  = '{1'b1,1'b1,3'd6,8'h40,3'd6,1'b0,6'h00,3'd5,1'b1};
    vt[7]  = '{1'b1,1'b1,3'd7,8'h80,3'd7,1'b0,6'h00,3'd5,1'b1};
    vt[8]  = '{1'b1,1'b0,3'd2,8'h80,3'd7,1'b0,6'h00,3'd5,1'b1};
    vt[9]  = '{1'b1,1'b0,3'd2,8'h80,3'd7,1'b0,6'h00,3'd5,1'b1};
    vt[10] = '{1'b1,1'b1,3'd2,8'h04,3'd2,1'b0,6'h04,3'd2,1'b0};
    vt[11] = '{1'b1,1'b1,3'd6,8'h40,3'd6,1'b0,6'h00,3'd2,1'b1};
    vt[12] = '{1'b1,1'b1,3'd5,8'h20,3'd5,1'b0,6'h20,3'd5,1'b0};
    vt[13] = '{1'b0,1'b1,3'd3,8'h00,3'd0,1'b0,6'h00,3'd0,1'b0};
    vt[14] = '{1'b1,1'b1,3'd7,8'h80,3'd7,1'b0,6'h00,3'd0,1'b1};
    vt[15] = '{1'b0,1'b0,3'd0,8'h00,3'd0,1'b0,6'h00,3'd0,1'b0};
    vt[16] = '{1'b1,1'b0,3'd0,8'h00,3'd0,1'b0,6'h00,3'd0,1'b0};

    // ---------------- reset / enable ----------------
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0; dwell = 8'd0;
    step();
    step();
    mon_on = 1'b1;
    chk("rst_y8", 32'(y8), 32'h0);
    chk("rst_y6", 32'(y6), 32'h0);
    chk("rst_idx", 32'(idx8), 32'h0);
    chk("rst_err", 32'(err8), 32'h0);
    chk("rst_wrap", 32'(wrap8), 32'h0);
    chk("rst_state", 32'(st8), 32'h0);
    chk("rst_ready", 32'(sel_ready8), 32'h0);
    rst = 1'b0;
    step();
    chk("en0_ready", 32'(sel_ready8), 32'h0);
    chk("en0_y", 32'(y8), 32'h0);
    en = 1'b1; mode = 1'b0;
    #1;
    chk("en1_ready", 32'(sel_ready8), 32'h1);
    step();
    chk("direct_state", 32'(st8), 32'h1);

    // ---------------- direct vectors ----------------
    for (int i = 0; i < 17; i++) begin
      en = vt[i].en; sel_valid = vt[i].valid; sel = vt[i].sel;
      #1;
      chk("vec_ready", 32'(sel_ready8), 32'(vt[i].en));
      step();
      chk("vec_y8", 32'(y8), 32'(vt[i].y8));
      chk("vec_idx8", 32'(idx8), 32'(vt[i].idx8));
      chk("vec_err8", 32'(err8), 32'(vt[i].err8));
      chk("vec_y6", 32'(y6), 32'(vt[i].y6));
      chk("vec_idx6", 32'(idx6), 32'(vt[i].idx6));
      chk("vec_err6", 32'(err6), 32'(vt[i].err6));
    end

    // ---------------- scan, dwell=2 ----------------
    sel_valid = 1'b1; sel = 3'd4;   // ignored in scan
    mode = 1'b1; dwell = 8'd2;
    #1;
    chk("scan_ready", 32'(sel_ready8), 32'h0);
    step();
    chk("scan_state", 32'(st8), 32'h2);
    for (int p = 0; p < 8; p++) check_pos(p, 3, 1'b0);
    // Second sweep: position 0 already loaded with 2, new dwell applies at 1.
    dwell = 8'd0;
    check_pos(0, 3, 1'b1);
    for (int p = 1; p < 8; p++) check_pos(p, 1, 1'b0);
    check_pos(0, 1, 1'b1);
    for (int p = 1; p < 5; p++) check_pos(p, 1, 1'b0);

    // ---------------- mode switch at idx 5 ----------------
    chk("sw_idx5", 32'(idx8), 32'h5);
    chk("sw_y5", 32'(y8), 32'h20);
    mode = 1'b0; sel_valid = 1'b1; sel = 3'd3;
    #1;
    chk("sw_ready", 32'(sel_ready8), 32'h1);
    step();
    chk("sw_y", 32'(y8), 32'h08);
    chk("sw_idx", 32'(idx8), 32'h3);
    chk("sw_err", 32'(err8), 32'h0);
    chk("sw_state", 32'(st8), 32'h1);
    sel_valid = 1'b0; mode = 1'b1;
    step();
    chk("re_scan_y", 32'(y8), 32'h01);
    chk("re_scan_idx", 32'(idx8), 32'h0);
    chk("re_scan_wrap", 32'(wrap8), 32'h0);
    // Scan -> direct with no transfer clears y.
    mode = 1'b0;
    step();
    chk("sd_y", 32'(y8), 32'h0);
    chk("sd_err", 32'(err8), 32'h0);
    // err set in direct is cleared on scan entry.
    sel_valid = 1'b1; sel = 3'd6;
    step();
    chk("e6_err", 32'(err6), 32'h1);
    sel_valid = 1'b0; mode = 1'b1; dwell = 8'd3;
    step();
    chk("e6_scan_err", 32'(err6), 32'h0);
    chk("e6_scan_y", 32'(y6), 32'h01);

    // ---------------- reset mid-dwell ----------------
    step();
    chk("md_y", 32'(y8), 32'h01);
    rst = 1'b1; mode = 1'b0;
    #1;
    chk("rst_ready_hi", 32'(sel_ready8), 32'h0);
    mode = 1'b1;
    step();
    chk("md_rst_y", 32'(y8), 32'h0);
    chk("md_rst_idx", 32'(idx8), 32'h0);
    chk("md_rst_state", 32'(st8), 32'h0);
    rst = 1'b0;
    step();
    chk("md_rel_y", 32'(y8), 32'h01);
    chk("md_rel_idx", 32'(idx8), 32'h0);
    chk("md_rel_state", 32'(st8), 32'h2);

    mon_on = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
